ddr_app_arbiter: RTL and testbench
==================================

DDR_APP_ARBITER -- requirements
Module: ddr_app_arbiter

Interface
REQ-001 SHALL expose parameter NUM_CH, default 4, number of client channels (1..8).
REQ-002 SHALL expose parameter APP_ADDR_WIDTH, default 32, DDR app address width.
REQ-003 SHALL expose parameter APP_DATA_WIDTH, default 64, DDR app data width; APP_MASK_WIDTH = APP_DATA_WIDTH/8.
REQ-004 SHALL expose parameter RD_DEPTH, default 16, maximum outstanding reads (power of 2).
REQ-005 SHALL use one clock and synchronous active-high reset: clk  in  1  DDR UI clock; rst  in  1  sync reset, active high.
REQ-006 Client ports SHALL be: ch_req in NUM_CH; ch_we in NUM_CH (1=write); ch_addr in NUM_CH*APP_ADDR_WIDTH; ch_wdata in NUM_CH*APP_DATA_WIDTH; ch_wmask in NUM_CH*APP_MASK_WIDTH; ch_ack out NUM_CH; ch_rvalid out NUM_CH; ch_rdata out APP_DATA_WIDTH (shared).
REQ-007 App ports SHALL be: app_addr out; app_cmd out 3; app_en out 1; app_wdf_data out; app_wdf_end out 1; app_wdf_mask out; app_wdf_wren out 1; app_rd_data in; app_rd_data_valid in 1; app_rdy in 1; app_wdf_rdy in 1; init_calib_complete in 1.
REQ-008 SHALL provide rd_underflow  out  1  sticky error flag.

Function
REQ-009 FSM states SHALL be IDLE and ISSUE.
REQ-010 In IDLE, no grant SHALL occur while init_calib_complete=0.
REQ-011 Eligible channel: ch_req=1 and (ch_we=1 or outstanding-read count < RD_DEPTH); a pop in the same cycle does not count.
REQ-012 Grant SHALL be round-robin from pointer ptr (reset 0): lowest eligible index at or above ptr, wrapping; after a grant, ptr = granted+1 mod NUM_CH.
REQ-013 On grant, channel index, we, addr, wdata, wmask SHALL be registered and state goes to ISSUE; app_en asserts the next cycle (grant latency 1).
REQ-014 In ISSUE, app_cmd SHALL be 3'b000 for write, 3'b001 for read; app_addr from the latched address.
REQ-015 Read: app_en held until app_rdy=1; in that cycle the channel index is pushed to the tag FIFO, ch_ack[ch] pulses 1 cycle, state returns to IDLE.
REQ-016 Write: app_en and app_wdf_wren (with app_wdf_end = app_wdf_wren) asserted together; each deasserts independently after its own ready (app_rdy / app_wdf_rdy) is seen; ch_ack[ch] pulses in the cycle the second of the two completes (same cycle if both ready together); then IDLE.
REQ-017 No grant SHALL be made in the cycle ch_ack pulses; a channel holding ch_req after ack is a new request.
REQ-018 On app_rd_data_valid with tag FIFO non-empty: pop tag; next cycle ch_rvalid[tag] pulses 1 cycle with ch_rdata = captured app_rd_data (return latency 1; order = issue order).
REQ-019 On app_rd_data_valid with tag FIFO empty: data discarded, no ch_rvalid, rd_underflow set until reset.
REQ-020 Simultaneous tag push and pop SHALL leave the count unchanged; pointers wrap modulo RD_DEPTH.
REQ-021 At most one ch_ack and one ch_rvalid bit SHALL be high in any cycle; ch_rdata holds its last value when no ch_rvalid.

Reset
REQ-022 While rst=1: state IDLE, ptr 0, tag FIFO empty, rd_underflow 0, app_en, app_wdf_wren, app_wdf_end, ch_ack, ch_rvalid all 0; app_addr, app_cmd, app_wdf_data, app_wdf_mask, ch_rdata 0.
REQ-023 Reset mid-transaction SHALL abandon it with no ch_ack; in-flight read returns after reset are treated per REQ-019.

Verification
REQ-024 Calib low, ch_req=4'b0001 -> no app_en; raise calib -> app_en next cycle, app_cmd per ch_we.
REQ-025 All four channels request writes continuously, app_rdy=app_wdf_rdy=1 -> acks cycle ch0,ch1,ch2,ch3,ch0; one ack per 2 cycles.
REQ-026 Write with app_rdy=1 at cycle 1, app_wdf_rdy=1 at cycle 3 -> app_en drops after cycle 1, wren after cycle 3, ch_ack at cycle 3.
REQ-027 16 reads from ch2 with no app_rd_data_valid -> 17th read withheld, ch1 write still granted; one valid (data 0xDEAD_BEEF) -> read issued and ch_rvalid[2] with 0xDEAD_BEEF one cycle later.
REQ-028 Reads ch0 then ch3, returns A then B -> ch_rvalid[0]/A then ch_rvalid[3]/B.
REQ-029 app_rd_data_valid after reset with no reads -> rd_underflow=1, no ch_rvalid; rst -> rd_underflow=0.

Source files
------------

// File: rtl/ddr_app_arbiter.sv
// ddr_app_arbiter: round-robin arbitration of NUM_CH clients onto one DDR app port,
// with an in-order read tag FIFO that routes returned data back to the issuing client.
module ddr_app_arbiter #(
    parameter int NUM_CH = 4,
    parameter int APP_ADDR_WIDTH = 32,
    parameter int APP_DATA_WIDTH = 64,
    parameter int RD_DEPTH = 16,
    localparam int APP_MASK_WIDTH = APP_DATA_WIDTH / 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_CH-1:0]                  ch_req,
    input  logic [NUM_CH-1:0]                  ch_we,
    input  logic [NUM_CH*APP_ADDR_WIDTH-1:0]   ch_addr,
    input  logic [NUM_CH*APP_DATA_WIDTH-1:0]   ch_wdata,
    input  logic [NUM_CH*APP_MASK_WIDTH-1:0]   ch_wmask,
    output logic [NUM_CH-1:0]                  ch_ack,
    output logic [NUM_CH-1:0]                  ch_rvalid,
    output logic [APP_DATA_WIDTH-1:0]          ch_rdata,
    output logic [APP_ADDR_WIDTH-1:0]          app_addr,
    output logic [2:0]                         app_cmd,
    output logic                               app_en,
    output logic [APP_DATA_WIDTH-1:0]          app_wdf_data,
    output logic                               app_wdf_end,
    output logic [APP_MASK_WIDTH-1:0]          app_wdf_mask,
    output logic                               app_wdf_wren,
    input  logic [APP_DATA_WIDTH-1:0]          app_rd_data,
    input  logic                               app_rd_data_valid,
    input  logic                               app_rdy,
    input  logic                               app_wdf_rdy,
    input  logic                               init_calib_complete,
    output logic                               rd_underflow
);
    localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int PW = $clog2(RD_DEPTH);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t state;
    logic [CW-1:0] ptr, cur_ch, gnt, idx;
    logic found, done, push, pop;
    logic [NUM_CH-1:0] elig;
    logic [CW-1:0] tag_mem [RD_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0] cnt;

    assign elig = ch_req & (ch_we | {NUM_CH{cnt < (PW+1)'(RD_DEPTH)}});
    // Complete once every strobe raised for this command has seen its own ready.
    assign done = state == ISSUE && (!app_en || app_rdy) && (!app_wdf_wren || app_wdf_rdy);
    assign push = done && app_cmd[0];
    assign pop = app_rd_data_valid && cnt != '0;
    assign ch_ack = (done && !rst) ? NUM_CH'(1) << cur_ch : '0;

    always_comb begin
        gnt = '0;
        found = 1'b0;
        idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = CW'((int'(ptr) + i) % NUM_CH);
            if (!found && elig[idx]) begin
                found = 1'b1;
                gnt = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr <= '0;
            cur_ch <= '0;
            app_addr <= '0;
            app_cmd <= '0;
            app_en <= 1'b0;
            app_wdf_data <= '0;
            app_wdf_mask <= '0;
            app_wdf_wren <= 1'b0;
            app_wdf_end <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt <= '0;
            ch_rvalid <= '0;
            ch_rdata <= '0;
            rd_underflow <= 1'b0;
        end else begin
            if (state == IDLE) begin
                if (init_calib_complete && found) begin
                    state <= ISSUE;
                    ptr <= CW'((int'(gnt) + 1) % NUM_CH);
                    cur_ch <= gnt;
                    app_addr <= ch_addr[int'(gnt)*APP_ADDR_WIDTH +: APP_ADDR_WIDTH];
                    app_cmd <= ch_we[gnt] ? 3'b000 : 3'b001;
                    app_en <= 1'b1;
                    app_wdf_data <= ch_wdata[int'(gnt)*APP_DATA_WIDTH +: APP_DATA_WIDTH];
                    app_wdf_mask <= ch_wmask[int'(gnt)*APP_MASK_WIDTH +: APP_MASK_WIDTH];
                    app_wdf_wren <= ch_we[gnt];
                    app_wdf_end <= ch_we[gnt];
                end
            end else begin
                app_en <= app_en && !app_rdy;
                app_wdf_wren <= app_wdf_wren && !app_wdf_rdy;
                app_wdf_end <= app_wdf_wren && !app_wdf_rdy;
                state <= done ? IDLE : ISSUE;
            end
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + PW'(pop);
            cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
            ch_rvalid <= pop ? NUM_CH'(1) << tag_mem[rd_ptr] : '0;
            ch_rdata <= pop ? app_rd_data : ch_rdata;
            rd_underflow <= rd_underflow || (app_rd_data_valid && cnt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            tag_mem[wr_ptr] <= cur_ch;
    end
endmodule

// File: tb/tb_ddr_app_arbiter.sv
// tb_ddr_app_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_ddr_app_arbiter;
    localparam int NUM_CH = 4;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int MW = DW / 8;
    localparam int RD_DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NUM_CH-1:0] ch_req = '0, ch_we = '0, ch_ack, ch_rvalid;
    logic [NUM_CH*AW-1:0] ch_addr = '0;
    logic [NUM_CH*DW-1:0] ch_wdata = '0;
    logic [NUM_CH*MW-1:0] ch_wmask = '0;
    logic [DW-1:0] ch_rdata, app_wdf_data, app_rd_data = '0;
    logic [AW-1:0] app_addr;
    logic [2:0] app_cmd;
    logic [MW-1:0] app_wdf_mask;
    logic app_en, app_wdf_end, app_wdf_wren, rd_underflow;
    logic app_rd_data_valid = 1'b0, app_rdy = 1'b0, app_wdf_rdy = 1'b0, init_calib_complete = 1'b0;
    int vectors = 0;
    int miscompares = 0;

    ddr_app_arbiter #(.NUM_CH(NUM_CH), .APP_ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW), .RD_DEPTH(RD_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_wmask(ch_wmask),
        .ch_ack(ch_ack), .ch_rvalid(ch_rvalid), .ch_rdata(ch_rdata),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_wdf_data(app_wdf_data),
        .app_wdf_end(app_wdf_end), .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid), .app_rdy(app_rdy),
        .app_wdf_rdy(app_wdf_rdy), .init_calib_complete(init_calib_complete), .rd_underflow(rd_underflow)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ch_req = '0;
        ch_we = '0;
        app_rd_data_valid = 1'b0;
        app_rdy = 1'b0;
        app_wdf_rdy = 1'b0;
        init_calib_complete = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        init_calib_complete = 1'b1;
        ch_req = '1;
        ch_we = '1;
        app_rdy = 1'b1;
        app_wdf_rdy = 1'b1;
        cyc();
        cyc();
        #2;
        vectors++;
        if ({app_en, app_wdf_wren, app_wdf_end} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_strobes: got %b expected 000", {app_en, app_wdf_wren, app_wdf_end});
        end
        vectors++;
        if ({ch_ack, ch_rvalid, rd_underflow} !== '0) begin
            miscompares++;
            $display("FAIL reset_client: got ack=%b rvalid=%b uf=%b expected all 0", ch_ack, ch_rvalid, rd_underflow);
        end
        vectors++;
        if (app_addr !== '0 || app_cmd !== '0 || app_wdf_data !== '0 || app_wdf_mask !== '0 || ch_rdata !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got addr=%h cmd=%b wdata=%h mask=%h rdata=%h expected 0", app_addr, app_cmd, app_wdf_data, app_wdf_mask, ch_rdata);
        end
        rst = 1'b0;
        clear_inputs();
        cyc();
    endtask

    task automatic test_calib();
        do_reset();
        ch_req = 4'b0001;
        ch_addr[0 +: AW] = 32'h0000_1000;
        for (int i = 0; i < 3; i++) begin
            #2;
            vectors++;
            if (app_en !== 1'b0) begin
                miscompares++;
                $display("FAIL calib_low_en: got %b expected 0", app_en);
            end
            cyc();
        end
        init_calib_complete = 1'b1;
        cyc();
        #2;
        vectors++;
        if (app_en !== 1'b1 || app_cmd !== 3'b001 || app_addr !== 32'h0000_1000) begin
            miscompares++;
            $display("FAIL calib_read_issue: got en=%b cmd=%b addr=%h expected 1 001 00001000", app_en, app_cmd, app_addr);
        end
        app_rdy = 1'b1;
        #2;
        vectors++;
        if (ch_ack !== 4'b0001) begin
            miscompares++;
            $display("FAIL calib_read_ack: got %b expected 0001", ch_ack);
        end
        ch_req = '0;
        cyc();
        #2;
        vectors++;
        if (app_en !== 1'b0) begin
            miscompares++;
            $display("FAIL calib_en_drop: got %b expected 0", app_en);
        end
        app_rd_data_valid = 1'b1;
        app_rd_data = 64'h1234;
        cyc();
        app_rd_data_valid = 1'b0;
        app_rdy = 1'b0;
        ch_we = 4'b0010;
        ch_req = 4'b0010;
        #2;
        vectors++;
        if (ch_rvalid !== 4'b0001 || ch_rdata !== 64'h1234) begin
            miscompares++;
            $display("FAIL calib_read_return: got %b/%h expected 0001/1234", ch_rvalid, ch_rdata);
        end
        cyc();
        #2;
        vectors++;
        if (app_en !== 1'b1 || app_cmd !== 3'b000 || app_wdf_wren !== 1'b1) begin
            miscompares++;
            $display("FAIL calib_write_issue: got en=%b cmd=%b wren=%b expected 1 000 1", app_en, app_cmd, app_wdf_wren);
        end
    endtask

    task automatic test_rr_writes();
        logic [NUM_CH-1:0] exp;
        do_reset();
        init_calib_complete = 1'b1;
        ch_req = '1;
        ch_we = '1;
        app_rdy = 1'b1;
        app_wdf_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #2;
            exp = (i % 2 == 1) ? 4'b0001 << ((i / 2) % 4) : 4'b0000;
            vectors++;
            if (ch_ack !== exp) begin
                miscompares++;
                $display("FAIL rr_ack_cycle%0d: got %b expected %b", i, ch_ack, exp);
            end
            cyc();
        end
    endtask

    task automatic test_split_ready();
        do_reset();
        init_calib_complete = 1'b1;
        ch_we = 4'b0010;
        ch_req = 4'b0010;
        ch_addr[AW +: AW] = 32'hCAFE_0040;
        ch_wdata[DW +: DW] = 64'h0123_4567_89AB_CDEF;
        ch_wmask[MW +: MW] = 8'h5A;
        cyc();
        app_rdy = 1'b1;
        #2;
        vectors++;
        if (app_en !== 1'b1 || app_wdf_wren !== 1'b1 || app_wdf_end !== 1'b1 || app_cmd !== 3'b000
            || app_addr !== 32'hCAFE_0040 || app_wdf_data !== 64'h0123_4567_89AB_CDEF || app_wdf_mask !== 8'h5A) begin
            miscompares++;
            $display("FAIL split_issue: got en=%b wren=%b end=%b cmd=%b addr=%h data=%h mask=%h", app_en, app_wdf_wren, app_wdf_end, app_cmd, app_addr, app_wdf_data, app_wdf_mask);
        end
        vectors++;
        if (ch_ack !== 4'b0000) begin
            miscompares++;
            $display("FAIL split_early_ack: got %b expected 0000", ch_ack);
        end
        cyc();
        app_rdy = 1'b0;
        #2;
        vectors++;
        if (app_en !== 1'b0 || app_wdf_wren !== 1'b1 || app_wdf_end !== 1'b1 || ch_ack !== 4'b0000) begin
            miscompares++;
            $display("FAIL split_cycle2: got en=%b wren=%b end=%b ack=%b expected 0 1 1 0000", app_en, app_wdf_wren, app_wdf_end, ch_ack);
        end
        cyc();
        app_wdf_rdy = 1'b1;
        #2;
        vectors++;
        if (ch_ack !== 4'b0010 || app_wdf_wren !== 1'b1) begin
            miscompares++;
            $display("FAIL split_ack: got ack=%b wren=%b expected 0010 1", ch_ack, app_wdf_wren);
        end
        ch_req = '0;
        cyc();
        #2;
        vectors++;
        if (app_wdf_wren !== 1'b0 || app_wdf_end !== 1'b0 || app_en !== 1'b0) begin
            miscompares++;
            $display("FAIL split_done: got wren=%b end=%b en=%b expected 0 0 0", app_wdf_wren, app_wdf_end, app_en);
        end
    endtask

    task automatic test_rd_depth();
        int acks = 0;
        int seen1 = 0;
        int seen2 = 0;
        do_reset();
        init_calib_complete = 1'b1;
        app_rdy = 1'b1;
        app_wdf_rdy = 1'b1;
        ch_req = 4'b0100;
        for (int i = 0; i < 40 && acks < RD_DEPTH; i++) begin
            #2;
            if (ch_ack[2]) acks++;
            cyc();
        end
        vectors++;
        if (acks !== RD_DEPTH) begin
            miscompares++;
            $display("FAIL depth_fill: got %0d reads acked expected %0d", acks, RD_DEPTH);
        end
        ch_we[1] = 1'b1;
        ch_req[1] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #2;
            if (ch_ack[1]) begin
                seen1++;
                ch_req[1] = 1'b0;
            end
            if (ch_ack[2]) seen2++;
            cyc();
        end
        vectors++;
        if (seen1 !== 1 || seen2 !== 0) begin
            miscompares++;
            $display("FAIL depth_withhold: got ch1 acks=%0d ch2 acks=%0d expected 1 0", seen1, seen2);
        end
        app_rd_data_valid = 1'b1;
        app_rd_data = 64'hDEAD_BEEF;
        cyc();
        app_rd_data_valid = 1'b0;
        #2;
        vectors++;
        if (ch_rvalid !== 4'b0100 || ch_rdata !== 64'hDEAD_BEEF || app_en !== 1'b0) begin
            miscompares++;
            $display("FAIL depth_return: got rvalid=%b rdata=%h en=%b expected 0100 deadbeef 0", ch_rvalid, ch_rdata, app_en);
        end
        cyc();
        #2;
        vectors++;
        if (app_en !== 1'b1 || app_cmd !== 3'b001 || ch_rvalid !== 4'b0000) begin
            miscompares++;
            $display("FAIL depth_reissue: got en=%b cmd=%b rvalid=%b expected 1 001 0000", app_en, app_cmd, ch_rvalid);
        end
    endtask

    task automatic test_rd_order();
        int order[$];
        do_reset();
        init_calib_complete = 1'b1;
        app_rdy = 1'b1;
        ch_req = 4'b1001;
        for (int i = 0; i < 10; i++) begin
            #2;
            for (int c = 0; c < NUM_CH; c++)
                if (ch_ack[c]) begin
                    order.push_back(c);
                    ch_req[c] = 1'b0;
                end
            cyc();
        end
        vectors++;
        if (order.size() != 2 || order[0] != 0 || order[1] != 3) begin
            miscompares++;
            $display("FAIL order_issue: got %0d acks expected ch0 then ch3", order.size());
        end
        app_rd_data_valid = 1'b1;
        app_rd_data = 64'hAAAA_0000_AAAA_0001;
        cyc();
        app_rd_data = 64'hBBBB_0000_BBBB_0002;
        #2;
        vectors++;
        if (ch_rvalid !== 4'b0001 || ch_rdata !== 64'hAAAA_0000_AAAA_0001) begin
            miscompares++;
            $display("FAIL order_first: got %b/%h expected 0001/aaaa0000aaaa0001", ch_rvalid, ch_rdata);
        end
        cyc();
        app_rd_data_valid = 1'b0;
        #2;
        vectors++;
        if (ch_rvalid !== 4'b1000 || ch_rdata !== 64'hBBBB_0000_BBBB_0002) begin
            miscompares++;
            $display("FAIL order_second: got %b/%h expected 1000/bbbb0000bbbb0002", ch_rvalid, ch_rdata);
        end
        cyc();
        #2;
        vectors++;
        if (ch_rvalid !== 4'b0000 || ch_rdata !== 64'hBBBB_0000_BBBB_0002) begin
            miscompares++;
            $display("FAIL order_hold: got %b/%h expected 0000/bbbb0000bbbb0002", ch_rvalid, ch_rdata);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        init_calib_complete = 1'b1;
        app_rd_data_valid = 1'b1;
        cyc();
        app_rd_data_valid = 1'b0;
        #2;
        vectors++;
        if (rd_underflow !== 1'b1 || ch_rvalid !== 4'b0000) begin
            miscompares++;
            $display("FAIL underflow_set: got uf=%b rvalid=%b expected 1 0000", rd_underflow, ch_rvalid);
        end
        ch_req = 4'b0001;
        cyc();
        #2;
        vectors++;
        if (rd_underflow !== 1'b1 || app_en !== 1'b1) begin
            miscompares++;
            $display("FAIL underflow_sticky: got uf=%b en=%b expected 1 1", rd_underflow, app_en);
        end
        rst = 1'b1;
        app_rdy = 1'b1;
        #2;
        vectors++;
        if (ch_ack !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_abandon_ack: got %b expected 0000", ch_ack);
        end
        cyc();
        #2;
        vectors++;
        if (rd_underflow !== 1'b0 || app_en !== 1'b0) begin
            miscompares++;
            $display("FAIL underflow_clear: got uf=%b en=%b expected 0 0", rd_underflow, app_en);
        end
        rst = 1'b0;
        ch_req = '0;
        app_rdy = 1'b0;
        cyc();
        app_rd_data_valid = 1'b1;
        cyc();
        app_rd_data_valid = 1'b0;
        #2;
        vectors++;
        if (rd_underflow !== 1'b1 || ch_rvalid !== 4'b0000) begin
            miscompares++;
            $display("FAIL late_return: got uf=%b rvalid=%b expected 1 0000", rd_underflow, ch_rvalid);
        end
    endtask

    task automatic test_random();
        bit pend [NUM_CH];
        bit cwe [NUM_CH];
        logic [AW-1:0] caddr [NUM_CH];
        logic [DW-1:0] cdata [NUM_CH];
        logic [MW-1:0] cmask [NUM_CH];
        int q[$];
        bit busy = 0, en_p = 0, wr_p = 0, m_we = 0, m_uf = 0;
        int m_ch = 0, m_ptr = 0, rv_ch = -1, sz;
        logic [AW-1:0] m_addr = '0;
        logic [DW-1:0] m_data = '0, rv_data = '0;
        logic [MW-1:0] m_mask = '0;
        logic [NUM_CH-1:0] exp_ack, exp_rv;
        do_reset();
        for (int c = 0; c < NUM_CH; c++) pend[c] = 0;
        for (int t = 0; t < 3000; t++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!pend[c] && $urandom_range(0, 2) == 0) begin
                    pend[c] = 1;
                    cwe[c] = 1'($urandom_range(0, 1));
                    caddr[c] = $urandom;
                    cdata[c] = {$urandom, $urandom};
                    cmask[c] = 8'($urandom);
                end
                ch_req[c] = pend[c];
                ch_we[c] = cwe[c];
                ch_addr[c*AW +: AW] = caddr[c];
                ch_wdata[c*DW +: DW] = cdata[c];
                ch_wmask[c*MW +: MW] = cmask[c];
            end
            init_calib_complete = $urandom_range(0, 19) != 0;
            app_rdy = $urandom_range(0, 3) != 0;
            app_wdf_rdy = $urandom_range(0, 3) != 0;
            app_rd_data_valid = q.size() > 0 && $urandom_range(0, 9) < (t < 1500 ? 2 : 6);
            app_rd_data = {$urandom, $urandom};
            #2;
            exp_ack = '0;
            if (busy && (!en_p || app_rdy) && (!wr_p || app_wdf_rdy)) exp_ack[m_ch] = 1'b1;
            exp_rv = rv_ch < 0 ? 4'b0000 : 4'b0001 << rv_ch;
            vectors++;
            if (ch_ack !== exp_ack) begin
                miscompares++;
                $display("FAIL rand_ack t=%0d: got %b expected %b", t, ch_ack, exp_ack);
            end
            vectors++;
            if (app_en !== (busy && en_p) || app_wdf_wren !== (busy && wr_p) || app_wdf_end !== (busy && wr_p)) begin
                miscompares++;
                $display("FAIL rand_strobes t=%0d: got en=%b wren=%b end=%b expected %b %b %b", t, app_en, app_wdf_wren, app_wdf_end, busy && en_p, busy && wr_p, busy && wr_p);
            end
            if (busy) begin
                vectors++;
                if (app_addr !== m_addr || app_cmd !== (m_we ? 3'b000 : 3'b001)) begin
                    miscompares++;
                    $display("FAIL rand_cmd t=%0d: got addr=%h cmd=%b expected %h we=%b", t, app_addr, app_cmd, m_addr, m_we);
                end
            end
            if (busy && wr_p) begin
                vectors++;
                if (app_wdf_data !== m_data || app_wdf_mask !== m_mask) begin
                    miscompares++;
                    $display("FAIL rand_wdata t=%0d: got %h/%h expected %h/%h", t, app_wdf_data, app_wdf_mask, m_data, m_mask);
                end
            end
            vectors++;
            if (ch_rvalid !== exp_rv || (rv_ch >= 0 && ch_rdata !== rv_data)) begin
                miscompares++;
                $display("FAIL rand_rvalid t=%0d: got %b/%h expected %b/%h", t, ch_rvalid, ch_rdata, exp_rv, rv_data);
            end
            vectors++;
            if (rd_underflow !== m_uf) begin
                miscompares++;
                $display("FAIL rand_underflow t=%0d: got %b expected %b", t, rd_underflow, m_uf);
            end
            sz = q.size();
            rv_ch = -1;
            if (app_rd_data_valid) begin
                if (sz > 0) begin
                    rv_ch = q.pop_front();
                    rv_data = app_rd_data;
                end else m_uf = 1;
            end
            if (busy) begin
                if (exp_ack != '0) begin
                    if (!m_we) q.push_back(m_ch);
                    busy = 0;
                    pend[m_ch] = 0;
                end else begin
                    en_p = en_p && !app_rdy;
                    wr_p = wr_p && !app_wdf_rdy;
                end
            end else if (init_calib_complete) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    int c;
                    c = (m_ptr + i) % NUM_CH;
                    if (pend[c] && (cwe[c] || sz < RD_DEPTH)) begin
                        busy = 1;
                        m_ch = c;
                        m_we = cwe[c];
                        m_addr = caddr[c];
                        m_data = cdata[c];
                        m_mask = cmask[c];
                        en_p = 1;
                        wr_p = cwe[c];
                        m_ptr = (c + 1) % NUM_CH;
                        break;
                    end
                end
            end
            cyc();
        end
    endtask

    initial begin
        cyc();
        test_reset();
        test_calib();
        test_rr_writes();
        test_split_ready();
        test_rd_depth();
        test_rd_order();
        test_underflow();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
